fp_operand_stage: RTL and testbench

//  Pipeline stage directly downstream of the operand unpacker pair. Accepts unpacked fields of operands
//  A and B (single or double) under valid/ready, classifies each operand, computes its true unbiased-base

---
 rtl/fpu_pkg.sv | 39 +++
 rtl/fp_classify.sv | 44 ++++
 rtl/fp_operand_stage.sv | 154 +++++++++++++++
 tb/tb_fp_operand_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_pkg
//  Purpose  : Shared widths, operand class encoding and operand/pair records
//             for the FP operand stage.
//  Revision : 1.0  initial release
// ============================================================================
package fpu_pkg;

    localparam int EW  = 13;  // signed true exponent width
    localparam int FW  = 53;  // significand width incl. hidden bit
    localparam int LZW = 6;   // unpacker leading-zero count width
    localparam int XW  = 11;  // biased exponent field width
    localparam int HW  = 52;  // raw fraction field width

    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        DENORM = 3'd1,
        NORM   = 3'd2,
        INF    = 3'd3,
        QNAN   = 3'd4,
        SNAN   = 3'd5
    } fp_class_t;

    typedef struct packed {
        logic          s;
        logic [EW-1:0] et;
        logic [FW-1:0] f;
        fp_class_t     cls;
    } fp_opnd_t;

    typedef struct packed {
        logic     db;
        fp_opnd_t a;
        fp_opnd_t b;
    } fp_pair_t;

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
//  Module   : fp_classify
//  Purpose  : Combinational operand classifier and true-exponent computation
//             from the unpacker's field flags.
//  Revision : 1.0  initial release
// ============================================================================
module fp_classify
    import fpu_pkg::*;
(
    input  logic [XW-1:0]  e_i,
    input  logic [LZW-1:0] lz_i,
    input  logic           fz_i,
    input  logic [HW-1:0]  h_i,
    input  logic           einf_i,
    input  logic           ez_i,
    output fp_class_t      cls_o,
    output logic [EW-1:0]  et_o
);

    logic [EW-1:0] w_base;

    // Denormals share the minimum normal exponent; the unpacker's shift is
    // then removed. The result always fits EW bits, so no saturation.
    assign w_base = ez_i ? {{(EW-1){1'b0}}, 1'b1} : {{(EW-XW){1'b0}}, e_i};
    assign et_o   = w_base - {{(EW-LZW){1'b0}}, lz_i};

    // Class decode: zero-exponent cases first, then all-ones exponent cases.
    always_comb begin
        cls_o = NORM;
        if (ez_i) begin
            cls_o = fz_i ? ZERO : DENORM;
        end else if (einf_i) begin
            if (h_i == '0)
                cls_o = INF;
            else if (h_i[HW-1])
                cls_o = QNAN;
            else
                cls_o = SNAN;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fp_operand_stage
//  Purpose  : Classifies unpacked A/B operands, computes true exponents and
//             registers the pair through a 2-entry skid buffer so the unpack
//             to datapath path is cut without losing throughput.
//  Revision : 1.0  initial release
// ============================================================================
module fp_operand_stage
    import fpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           db_in,
    input  logic           a_s,
    input  logic [XW-1:0]  a_e,
    input  logic [LZW-1:0] a_lz,
    input  logic [FW-1:0]  a_f,
    input  logic           a_fz,
    input  logic [HW-1:0]  a_h,
    input  logic           a_einf,
    input  logic           a_ez,
    input  logic           b_s,
    input  logic [XW-1:0]  b_e,
    input  logic [LZW-1:0] b_lz,
    input  logic [FW-1:0]  b_f,
    input  logic           b_fz,
    input  logic [HW-1:0]  b_h,
    input  logic           b_einf,
    input  logic           b_ez,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_db,
    output logic           a_sq,
    output logic [EW-1:0]  a_et,
    output logic [FW-1:0]  a_fq,
    output fp_class_t      a_cls,
    output logic           b_sq,
    output logic [EW-1:0]  b_et,
    output logic [FW-1:0]  b_fq,
    output fp_class_t      b_cls,
    output logic           invalid,
    output logic           nan_out
);

    fp_class_t     w_a_cls, w_b_cls;
    logic [EW-1:0] w_a_et,  w_b_et;
    fp_pair_t      w_in;
    logic          w_acc, w_drain;

    fp_pair_t main_q, main_d, skid_q, skid_d;
    logic     main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic     in_ready_q, in_ready_d;

    fp_classify u_cls_a (
        .e_i    (a_e),
        .lz_i   (a_lz),
        .fz_i   (a_fz),
        .h_i    (a_h),
        .einf_i (a_einf),
        .ez_i   (a_ez),
        .cls_o  (w_a_cls),
        .et_o   (w_a_et)
    );

    fp_classify u_cls_b (
        .e_i    (b_e),
        .lz_i   (b_lz),
        .fz_i   (b_fz),
        .h_i    (b_h),
        .einf_i (b_einf),
        .ez_i   (b_ez),
        .cls_o  (w_b_cls),
        .et_o   (w_b_et)
    );

    assign w_in.db    = db_in;
    assign w_in.a.s   = a_s;
    assign w_in.a.et  = w_a_et;
    assign w_in.a.f   = a_f;
    assign w_in.a.cls = w_a_cls;
    assign w_in.b.s   = b_s;
    assign w_in.b.et  = w_b_et;
    assign w_in.b.f   = b_f;
    assign w_in.b.cls = w_b_cls;

    assign w_acc   = in_valid & in_ready_q;
    assign w_drain = ~main_v_q | out_ready;

    // Skid-buffer next state: main refills from skid first (FIFO order),
    // otherwise from the input; a stalled main diverts input into skid.
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (w_drain) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else if (w_acc) begin
                main_d   = w_in;
                main_v_d = 1'b1;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (w_acc) begin
            skid_d   = w_in;
            skid_v_d = 1'b1;
        end
        in_ready_d = ~skid_v_d;
    end

    // State registers; reset discards everything held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign out_db    = main_q.db;
    assign a_sq      = main_q.a.s;
    assign a_et      = main_q.a.et;
    assign a_fq      = main_q.a.f;
    assign a_cls     = main_q.a.cls;
    assign b_sq      = main_q.b.s;
    assign b_et      = main_q.b.et;
    assign b_fq      = main_q.b.f;
    assign b_cls     = main_q.b.cls;
    assign invalid   = (main_q.a.cls == SNAN) | (main_q.b.cls == SNAN);
    assign nan_out   = (main_q.a.cls == SNAN) | (main_q.b.cls == SNAN) |
                       (main_q.a.cls == QNAN) | (main_q.b.cls == QNAN);

endmodule
`default_nettype wire

// File: tb/tb_fp_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_operand_stage
//  Purpose  : Self-checking bench for fp_operand_stage: directed cases plus a
//             random valid/ready soak against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_operand_stage;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready, db_in;
    logic        a_s, a_fz, a_einf, a_ez, b_s, b_fz, b_einf, b_ez;
    logic [10:0] a_e, b_e;
    logic [5:0]  a_lz, b_lz;
    logic [52:0] a_f, b_f;
    logic [51:0] a_h, b_h;
    logic        in_ready, out_valid, out_db, a_sq, b_sq, invalid, nan_out;
    logic [12:0] a_et, b_et;
    logic [52:0] a_fq, b_fq;
    fp_class_t   a_cls, b_cls;

    fp_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .db_in(db_in),
        .a_s(a_s), .a_e(a_e), .a_lz(a_lz), .a_f(a_f), .a_fz(a_fz), .a_h(a_h),
        .a_einf(a_einf), .a_ez(a_ez),
        .b_s(b_s), .b_e(b_e), .b_lz(b_lz), .b_f(b_f), .b_fz(b_fz), .b_h(b_h),
        .b_einf(b_einf), .b_ez(b_ez),
        .out_valid(out_valid), .out_ready(out_ready), .out_db(out_db),
        .a_sq(a_sq), .a_et(a_et), .a_fq(a_fq), .a_cls(a_cls),
        .b_sq(b_sq), .b_et(b_et), .b_fq(b_fq), .b_cls(b_cls),
        .invalid(invalid), .nan_out(nan_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        db;
        logic        as;
        logic [12:0] aet;
        logic [52:0] af;
        logic [2:0]  acls;
        logic        bs;
        logic [12:0] bet;
        logic [52:0] bf;
        logic [2:0]  bcls;
    } pair_t;

    pair_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    pops   = 0;
    bit    acc_last = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference classification straight from the field flags.
    function automatic logic [2:0] ref_cls(input logic ez, input logic fz,
                                           input logic einf, input logic [51:0] h);
        if (ez)        return fz ? 3'd0 : 3'd1;          // ZERO / DENORM
        if (!einf)     return 3'd2;                      // NORM
        if (h == 52'd0) return 3'd3;                     // INF
        return h[51] ? 3'd4 : 3'd5;                      // QNAN / SNAN
    endfunction

    // Reference true exponent as plain integer arithmetic, then wrapped to 13 bits.
    function automatic logic [12:0] ref_et(input logic ez, input logic [10:0] e,
                                           input logic [5:0] lz);
        int v;
        v = (ez ? 1 : int'(e)) - int'(lz);
        return v[12:0];
    endfunction

    function automatic pair_t mk_pair();
        pair_t p;
        p.db   = db_in;
        p.as   = a_s;  p.aet = ref_et(a_ez, a_e, a_lz); p.af = a_f;
        p.acls = ref_cls(a_ez, a_fz, a_einf, a_h);
        p.bs   = b_s;  p.bet = ref_et(b_ez, b_e, b_lz); p.bf = b_f;
        p.bcls = ref_cls(b_ez, b_fz, b_einf, b_h);
        return p;
    endfunction

    // Compare visible DUT state against the model: capacity-2 FIFO.
    task automatic check_state();
        pair_t e;
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            e = q[0];
            chk("out_db", out_db, e.db);
            chk("a_sq", a_sq, e.as);   chk("a_et", a_et, e.aet);
            chk("a_fq", a_fq, e.af);   chk("a_cls", a_cls, e.acls);
            chk("b_sq", b_sq, e.bs);   chk("b_et", b_et, e.bet);
            chk("b_fq", b_fq, e.bf);   chk("b_cls", b_cls, e.bcls);
            chk("invalid", invalid, (e.acls == 3'd5) || (e.bcls == 3'd5));
            chk("nan_out", nan_out, (e.acls >= 3'd4) || (e.bcls >= 3'd4));
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic tick();
        bit fin, fout;
        fin  = in_valid && in_ready;
        fout = out_valid && out_ready;
        acc_last = 0;
        if (flush) begin
            q.delete();
        end else begin
            if (fout) begin void'(q.pop_front()); pops++; end
            if (fin)  begin q.push_back(mk_pair()); acc_last = 1; end
        end
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic set_norm_a(input logic [10:0] e);
        a_s = 1'b0; a_e = e; a_lz = 6'd0; a_f = 53'h10000000000000 | 53'(e);
        a_fz = 1'b1; a_h = 52'd0; a_einf = 1'b0; a_ez = 1'b0;
    endtask

    task automatic rand_op(output logic s, output logic [10:0] e, output logic [5:0] lz,
                           output logic [52:0] f, output logic fz, output logic [51:0] h,
                           output logic einf, output logic ez);
        int k;
        k  = $urandom_range(0, 4);
        s  = 1'($urandom);
        f  = 53'({$urandom, $urandom});
        h  = 52'({$urandom, $urandom});
        lz = 6'd0;
        case (k)
            0: begin e = 11'd0; h = 52'd0; end
            1: begin e = 11'd0; if (h == 52'd0) h = 52'd1; lz = 6'($urandom_range(1, 52)); end
            2: e = 11'($urandom_range(1, 2046));
            3: begin e = 11'h7FF; h = 52'd0; end
            default: begin e = 11'h7FF; if (h == 52'd0) h = 52'd3; end
        endcase
        if ($urandom_range(0, 3) == 0) lz = 6'($urandom);
        fz   = (h == 52'd0);
        ez   = (e == 11'd0);
        einf = (e == 11'h7FF);
    endtask

    initial begin
        int p0, cyc;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; db_in = 1'b0;
        set_norm_a(11'd0);
        b_s = 1'b0; b_e = 11'd0; b_lz = 6'd0; b_f = 53'd0; b_fz = 1'b1; b_h = 52'd0;
        b_einf = 1'b0; b_ez = 1'b1;
        #12;
        // Reset state: everything cleared, ready to accept.
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_a_et", a_et, 0);   chk("rst_a_fq", a_fq, 0);
        chk("rst_a_cls", a_cls, 0); chk("rst_b_et", b_et, 0);
        chk("rst_out_db", out_db, 0);
        chk("rst_flags", {invalid, nan_out, a_sq, b_sq}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: double 1.0 and +0.
        db_in = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        set_norm_a(11'h3FF); a_f = 53'h10000000000000;
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_a_et", a_et, 13'h03FF);
        chk("t1_a_cls", a_cls, NORM);
        chk("t1_b_cls", b_cls, ZERO);
        chk("t1_b_et", b_et, 13'h0001);

        // 2: minimum double denormal.
        a_e = 11'd0; a_ez = 1'b1; a_lz = 6'd52; a_fz = 1'b0; a_h = 52'd1;
        tick();
        chk("t2_a_et", a_et, 13'h1FCD);
        chk("t2_a_cls", a_cls, DENORM);

        // 3: signalling then quiet NaN.
        a_e = 11'h7FF; a_ez = 1'b0; a_einf = 1'b1; a_lz = 6'd0; a_h = 52'h1; a_fz = 1'b0;
        tick();
        chk("t3_snan_cls", a_cls, SNAN);
        chk("t3_snan_inv", invalid, 1);
        chk("t3_snan_nan", nan_out, 1);
        a_h = 52'h8000000000000;
        tick();
        chk("t3_qnan_cls", a_cls, QNAN);
        chk("t3_qnan_inv", invalid, 0);
        chk("t3_qnan_nan", nan_out, 1);
        in_valid = 1'b0;
        tick();

        // 4: stall, push three pairs back-to-back, then release.
        out_ready = 1'b0; in_valid = 1'b1; p0 = pops;
        set_norm_a(11'd1); tick();
        set_norm_a(11'd2); tick();
        chk("t4_ready_low", in_ready, 0);
        set_norm_a(11'd3); tick();
        chk("t4_hold_head", a_et, 13'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (acc_last) in_valid = 1'b0;
        end
        chk("t4_pair_count", pops - p0, 3);

        // 5: flush a full buffer while presenting new input.
        out_ready = 1'b0; in_valid = 1'b1;
        set_norm_a(11'd10); tick();
        set_norm_a(11'd11); tick();
        flush = 1'b1; set_norm_a(11'd12); tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_valid", out_valid, 0);
        chk("t5_ready", in_ready, 1);
        out_ready = 1'b1;
        tick(); tick();
        chk("t5_no_ghost", out_valid, 0);

        // 6: asynchronous reset between edges with data held.
        out_ready = 1'b0; in_valid = 1'b1;
        set_norm_a(11'd20); tick();
        set_norm_a(11'd21); tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_ready", in_ready, 1);
        chk("t6_a_et", a_et, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Random soak: 10k pairs through random valid/ready with rare flushes.
        p0 = pops; cyc = 0; in_valid = 1'b0;
        while ((pops - p0) < 10000 && cyc < 60000) begin
            if (!in_valid || acc_last) begin
                rand_op(a_s, a_e, a_lz, a_f, a_fz, a_h, a_einf, a_ez);
                rand_op(b_s, b_e, b_lz, b_f, b_fz, b_h, b_einf, b_ez);
                db_in    = 1'($urandom);
                in_valid = ($urandom_range(0, 9) < 7);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 999) == 0);
            tick();
            cyc++;
        end
        chk("soak_done", (pops - p0) >= 10000, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
